// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for the immediate-extension stage: extension-mode
// encodings as seen on in_mode, and the occupancy states of the two-entry
// output buffer.
// -----------------------------------------------------------------------------
package imm_ext_pkg;

   typedef logic [1:0] imm_mode_t;

   localparam imm_mode_t MODE_SEXT   = 2'b00;
   localparam imm_mode_t MODE_ZEXT   = 2'b01;
   localparam imm_mode_t MODE_LUI    = 2'b10;
   localparam imm_mode_t MODE_BRANCH = 2'b11;

   // Occupancy of the main + skid storage, named by entry count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate widener.
//   i_imm  [IN_W-1:0]   raw immediate field
//   i_mode [1:0]        SEXT / ZEXT / LUI / BRANCH
//   o_ext  [OUT_W-1:0]  extended immediate
// -----------------------------------------------------------------------------
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  i_imm,
   input  imm_mode_t        i_mode,
   output logic [OUT_W-1:0] o_ext
);

   // The BRANCH shift needs two spare bits above the sign-extended field.
   if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_core: OUT_W must be at least IN_W+2");
   end

   logic signed [OUT_W-1:0] w_sext;
   logic        [OUT_W-1:0] w_zext;
   logic        [OUT_W-1:0] w_lui;
   logic        [OUT_W-1:0] w_branch;

   assign w_sext   = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
   assign w_zext   = {{(OUT_W-IN_W){1'b0}}, i_imm};
   assign w_lui    = {i_imm, {(OUT_W-IN_W){1'b0}}};
   // Word-scaled offset: the two top bits of the sign extension fall off.
   assign w_branch = {w_sext[OUT_W-3:0], 2'b00};

   always_comb begin
      o_ext = w_sext;
      case (i_mode)
         MODE_SEXT   : o_ext = w_sext;
         MODE_ZEXT   : o_ext = w_zext;
         MODE_LUI    : o_ext = w_lui;
         MODE_BRANCH : o_ext = w_branch;
         default     : o_ext = w_sext;
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
// One registered pipeline stage between decode and the ALU operand mux that
// widens the instruction immediate. Valid/ready on both sides, a main entry
// driving the outputs plus one skid entry, strict FIFO order.
//   clk, rst_n (async, active-low), flush (sync, active-high)
//   in_valid / in_ready / in_imm / in_mode / in_tag   : upstream side
//   out_valid / out_ready / out_imm / out_tag         : downstream side
// -----------------------------------------------------------------------------
module imm_extend_stage
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag
);

   occ_state_t         r_state;
   occ_state_t         w_state_nxt;
   logic               r_in_ready;
   logic [OUT_W-1:0]   r_main_imm;
   logic [TAG_W-1:0]   r_main_tag;
   logic [OUT_W-1:0]   r_skid_imm;
   logic [TAG_W-1:0]   r_skid_tag;

   logic [OUT_W-1:0]   w_ext;
   logic               w_acc;
   logic               w_ret;
   logic               w_ld_main_new;
   logic               w_ld_main_skid;
   logic               w_ld_skid;

   // Extension happens on the input side so stored entries are final values.
   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .i_imm  (in_imm),
      .i_mode (imm_mode_t'(in_mode)),
      .o_ext  (w_ext)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != ST_EMPTY);
   assign out_imm   = r_main_imm;
   assign out_tag   = r_main_tag;

   assign w_acc = in_valid & r_in_ready;
   assign w_ret = out_valid & out_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_new  = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
         // Flush wins over any accept/retire; stored data is left untouched.
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  w_state_nxt   = ST_ONE;
                  w_ld_main_new = 1'b1;
               end
            end
            ST_ONE: begin
               case ({w_acc, w_ret})
                  2'b10: begin
                     w_state_nxt = ST_FULL;
                     w_ld_skid   = 1'b1;
                  end
                  2'b01: w_state_nxt = ST_EMPTY;
                  2'b11: w_ld_main_new = 1'b1;
                  default: ;
               endcase
            end
            ST_FULL: begin
               // in_ready is low here, so only a retire can happen.
               if (w_ret) begin
                  w_state_nxt    = ST_ONE;
                  w_ld_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
      end
   end

   // Main entry is visible on the outputs, so it powers up to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_imm <= '0;
         r_main_tag <= '0;
      end else if (w_ld_main_new) begin
         r_main_imm <= w_ext;
         r_main_tag <= in_tag;
      end else if (w_ld_main_skid) begin
         r_main_imm <= r_skid_imm;
         r_main_tag <= r_skid_tag;
      end
   end

   // Skid contents are only ever read after being written.
   always_ff @(posedge clk) begin
      if (w_ld_skid) begin
         r_skid_imm <= w_ext;
         r_skid_tag <= in_tag;
      end
   end

endmodule
